// File: rtl/reg_block_transfer.sv
// Load/store-multiple sequencer: walks a register bitmask, one memory word per selected register.
// Optional base-register writeback is built in when REG_BLOCK_WRITEBACK_EN is defined.
module reg_block_transfer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int REG_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 isLoad,
    input  logic [REG_COUNT-1:0] regList,
    input  logic [DATA_W-1:0]    baseAddr,
    input  logic [ADDR_W-1:0]    baseReg,
    output logic [ADDR_W-1:0]    rfReadAddr,
    input  logic [DATA_W-1:0]    rfReadData,
    output logic                 rfWriteEnable,
    output logic [ADDR_W-1:0]    rfWriteAddr,
    output logic [DATA_W-1:0]    rfWriteData,
    output logic                 memReq,
    output logic                 memWe,
    output logic [DATA_W-1:0]    memAddr,
    output logic [DATA_W-1:0]    memWData,
    input  logic [DATA_W-1:0]    memRData,
    input  logic                 memReady,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting for start
    // XFER  | memory access for lowest remaining register
    // WRITE | load data written to register file
    // WB    | base register writeback (optional build)
    // DONE  | one-cycle completion pulse
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_XFER  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
`ifdef REG_BLOCK_WRITEBACK_EN
    localparam logic [2:0] S_WB    = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [REG_COUNT-1:0] r_list;
    logic [DATA_W-1:0]    r_addr;
    logic                 r_is_load;
    logic [ADDR_W-1:0]    r_base_reg;
    logic [ADDR_W:0]      r_count;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
`ifdef REG_BLOCK_WRITEBACK_EN
    logic [DATA_W-1:0]    r_base_addr;
`endif

    logic [ADDR_W-1:0]    w_cur;
    logic [REG_COUNT-1:0] w_list_rest;
    logic [2:0]           w_end_state;

    always_comb begin
        w_cur = '0;
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (r_list[i]) w_cur = ADDR_W'(i);
        end
    end

    // Clearing the lowest set bit is the same as clearing bit w_cur.
    assign w_list_rest = r_list & (r_list - REG_COUNT'(1));

`ifdef REG_BLOCK_WRITEBACK_EN
    assign w_end_state = S_WB;
`else
    assign w_end_state = S_DONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_list     <= '0;
            r_addr     <= '0;
            r_is_load  <= 1'b0;
            r_base_reg <= '0;
            r_count    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
`ifdef REG_BLOCK_WRITEBACK_EN
            r_base_addr <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (|regList) begin
                            r_list     <= regList;
                            r_addr     <= baseAddr;
                            r_is_load  <= isLoad;
                            r_base_reg <= baseReg;
                            r_count    <= '0;
`ifdef REG_BLOCK_WRITEBACK_EN
                            r_base_addr <= baseAddr;
`endif
                            r_state    <= S_XFER;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_XFER: begin
                    if (memReady) begin
                        r_list  <= w_list_rest;
                        r_addr  <= r_addr + DATA_W'(4);
                        r_count <= r_count + 1'b1;
                        if (r_is_load) begin
                            r_wr_addr <= w_cur;
                            r_wr_data <= memRData;
                            r_state   <= S_WRITE;
                        end else begin
                            r_state <= (|w_list_rest) ? S_XFER : w_end_state;
                        end
                    end
                end
                S_WRITE: r_state <= (|r_list) ? S_XFER : w_end_state;
`ifdef REG_BLOCK_WRITEBACK_EN
                S_WB:    r_state <= S_DONE;
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign memReq     = (r_state == S_XFER);
    assign memWe      = memReq && !r_is_load;
    assign memAddr    = memReq ? r_addr : '0;
    assign rfReadAddr = memWe ? w_cur : '0;
    assign memWData   = memWe ? rfReadData : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

`ifdef REG_BLOCK_WRITEBACK_EN
    // Writeback lands after any load into baseReg, so it wins.
    assign rfWriteEnable = (r_state == S_WRITE) || (r_state == S_WB);
    assign rfWriteAddr   = (r_state == S_WRITE) ? r_wr_addr :
                           (r_state == S_WB)    ? r_base_reg : '0;
    assign rfWriteData   = (r_state == S_WRITE) ? r_wr_data :
                           (r_state == S_WB)    ? r_base_addr + DATA_W'({r_count, 2'b00}) : '0;
`else
    assign rfWriteEnable = (r_state == S_WRITE);
    assign rfWriteAddr   = (r_state == S_WRITE) ? r_wr_addr : '0;
    assign rfWriteData   = (r_state == S_WRITE) ? r_wr_data : '0;
`endif

endmodule

// File: tb/tb_reg_block_transfer.sv
// Scoreboard bench for reg_block_transfer: expected memory accesses and register writes are
// queued at start time and popped as the sequencer produces them.
module tb_reg_block_transfer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        isLoad;
    logic [15:0] regList;
    logic [31:0] baseAddr;
    logic [3:0]  baseReg;
    logic [3:0]  rfReadAddr;
    logic [31:0] rfReadData;
    logic        rfWriteEnable;
    logic [3:0]  rfWriteAddr;
    logic [31:0] rfWriteData;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memReady;
    logic        busy;
    logic        done;

    reg_block_transfer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .isLoad(isLoad), .regList(regList),
        .baseAddr(baseAddr), .baseReg(baseReg), .rfReadAddr(rfReadAddr), .rfReadData(rfReadData),
        .rfWriteEnable(rfWriteEnable), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memReady(memReady), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic we; } mem_exp_t;
    typedef struct { logic [3:0] addr; logic [31:0] data; } rf_exp_t;

    mem_exp_t exp_mem[$];
    rf_exp_t  exp_rf[$];
    logic [31:0] rf_model [16];
    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h200) return 32'h11;
        if (a == 32'h204) return 32'h22;
        return a ^ 32'hC0DE_0000;
    endfunction

    assign rfReadData = rf_model[rfReadAddr];
    assign memRData   = memReq ? mem_fn(memAddr) : 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (memReq) begin
                if (exp_mem.size() == 0) begin
                    check_val("mem_unexp", {31'b0, memReq}, 32'h0);
                end else begin
                    check_val("mem_addr", memAddr, exp_mem[0].addr);
                    check_val("mem_we", {31'b0, memWe}, {31'b0, exp_mem[0].we});
                    if (exp_mem[0].we) check_val("mem_wdata", memWData, exp_mem[0].data);
                    if (memReady) void'(exp_mem.pop_front());
                end
            end
            if (rfWriteEnable) begin
                if (exp_rf.size() == 0) begin
                    check_val("rf_unexp", {31'b0, rfWriteEnable}, 32'h0);
                end else begin
                    check_val("rf_waddr", {28'b0, rfWriteAddr}, {28'b0, exp_rf[0].addr});
                    check_val("rf_wdata", rfWriteData, exp_rf[0].data);
                    void'(exp_rf.pop_front());
                end
            end
        end
    end

    function automatic int exp_cycles(input logic load, input logic [15:0] list);
        int n;
        n = $countones(list);
        if (n == 0) return 1;
`ifdef REG_BLOCK_WRITEBACK_EN
        return (load ? 2 * n : n) + 2;
`else
        return (load ? 2 * n : n) + 1;
`endif
    endfunction

    task automatic issue(input logic load, input logic [15:0] list, input logic [31:0] base,
                         input logic [3:0] breg);
        logic [31:0] a;
        int cnt;
        a = base;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_mem.push_back('{addr: a, data: load ? mem_fn(a) : rf_model[i], we: !load});
                if (load) exp_rf.push_back('{addr: 4'(i), data: mem_fn(a)});
                a = a + 32'd4;
                cnt++;
            end
        end
`ifdef REG_BLOCK_WRITEBACK_EN
        if (list != 16'h0) exp_rf.push_back('{addr: breg, data: base + 32'(4 * cnt)});
`endif
        @(posedge clk); #1;
        start = 1'b1; isLoad = load; regList = list; baseAddr = base; baseReg = breg;
        @(posedge clk); #1;
        start = 1'b0; regList = 16'hFFFF; baseAddr = 32'hDEAD_0000;
        busy_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int cycles_exp);
        int cycles;
        cycles = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (done) break;
        end
        check_val({tag, "_done_cycle"}, cycles, cycles_exp);
        @(negedge clk); #1;
        check_val({tag, "_busy_cnt"}, busy_cnt, cycles_exp);
        check_val({tag, "_idle"}, {30'b0, busy, done}, 32'h0);
        check_val({tag, "_mem_left"}, exp_mem.size(), 0);
        check_val({tag, "_rf_left"}, exp_rf.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_ctl"}, {26'b0, memReq, memWe, rfWriteEnable, busy, done, 1'b0}, 32'h0);
        check_val({tag, "_maddr"}, memAddr, 32'h0);
        check_val({tag, "_mwdata"}, memWData, 32'h0);
        check_val({tag, "_rfw"}, {rfReadAddr, rfWriteAddr, 24'b0} | rfWriteData, 32'h0);
    endtask

    initial begin
        logic [15:0] list;
        logic        load;
        for (int i = 0; i < 16; i++) rf_model[i] = 32'hA0 + 32'(i);
        rf_model[0] = 32'hA;
        rf_model[2] = 32'hB;
        rst_n = 1'b0; start = 1'b0; isLoad = 1'b0; regList = '0; baseAddr = '0; baseReg = '0;
        memReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;

        issue(1'b0, 16'h0005, 32'h100, 4'd0);
        wait_done("store2", exp_cycles(1'b0, 16'h0005));

        issue(1'b1, 16'h8001, 32'h200, 4'd7);
        wait_done("load2", exp_cycles(1'b1, 16'h8001));

        issue(1'b0, 16'h0002, 32'h300, 4'd0);
        memReady = 1'b0;
        fork
            wait_done("stall", 5);
            begin
                repeat (3) @(negedge clk);
                @(posedge clk); #1;
                memReady = 1'b1;
            end
        join

        issue(1'b0, 16'h0000, 32'h400, 4'd3);
        wait_done("empty", 1);

        issue(1'b1, 16'h8001, 32'h200, 4'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_quiet("midrst");
        exp_mem.delete();
        exp_rf.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("post_rst_quiet", {30'b0, rfWriteEnable, busy}, 32'h0);
        end
        issue(1'b0, 16'h0005, 32'h100, 4'd0);
        wait_done("after_rst", exp_cycles(1'b0, 16'h0005));

        issue(1'b1, 16'h0006, 32'hFFFF_FFFC, 4'd4);
        wait_done("wrap", exp_cycles(1'b1, 16'h0006));

        issue(1'b1, 16'h0011, 32'h500, 4'd4);
        wait_done("load_base", exp_cycles(1'b1, 16'h0011));

        for (int t = 0; t < 6; t++) begin
            list = 16'($urandom_range(0, 65535));
            load = 1'($urandom_range(0, 1));
            issue(load, list, {$urandom_range(0, 32'h3FFF), 2'b00}, 4'($urandom_range(0, 15)));
            wait_done("rand", exp_cycles(load, list));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_block_transfer.md
Name: reg_block_transfer

Overview:
- Multi-cycle load/store-multiple sequencer that drives the register file from the opposite side.
- Walks a register-list bitmask and issues one data-memory word access per selected register.
- For stores, it reads registers through the register file read port and writes memory.
- For loads, it reads memory and writes registers through the register file write port.
- Sits between the control unit and the register file / data memory, and stalls the pipeline via busy.

Parameters:
- DATA_W, 32, data and address width
- ADDR_W, 4, register address width
- REG_COUNT, 16, register-list width; must equal 2**ADDR_W

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin transfer; sampled only in IDLE
- isLoad  input  1  1 = memory→registers, 0 = registers→memory
- regList  input  REG_COUNT  register selection bitmask
- baseAddr  input  DATA_W  first memory word address
- baseReg  input  ADDR_W  base register index, used for writeback
- rfReadAddr  output  ADDR_W  register file read address (store)
- rfReadData  input  DATA_W  register file read data, combinational
- rfWriteEnable  output  1  register file write strobe
- rfWriteAddr  output  ADDR_W  register file write address
- rfWriteData  output  DATA_W  register file write data
- memReq  output  1  memory request
- memWe  output  1  memory write (store)
- memAddr  output  DATA_W  memory word address
- memWData  output  DATA_W  memory write data
- memRData  input  DATA_W  memory read data, valid with memReady
- memReady  input  1  memory accepts or completes the request this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latched list, address and count cleared. Reset mid-transfer abandons the transfer; no register write is issued after reset.
- States: IDLE, XFER, WRITE, WB, DONE.
- IDLE:
  - start=1 with regList≠0: latch regList, baseAddr, isLoad and baseReg; count=0; go to XFER.
  - start=1 with regList=0: go directly to DONE; no memory access.
  - start=0: stay in IDLE.
- Register order: lowest set bit of the remaining list first, ascending. cur = index of the lowest remaining set bit.
- XFER:
  - Outputs: memReq=1; memAddr=current address; memWe=!isLoad.
  - Store: rfReadAddr=cur; memWData=rfReadData (combinational pass-through).
  - The transfer completes in the cycle where memReq&&memReady. Until then, memReq, memAddr and memWData are held stable.
  - On completion: clear bit cur; address += 4 (mod 2**DATA_W, wraps); count += 1.
  - Load on completion: capture memRData and cur, then go to WRITE.
  - Store on completion: go to XFER if bits remain, else to WB or DONE.
- WRITE (load only):
  - rfWriteEnable=1 for exactly one cycle, with rfWriteAddr=captured cur and rfWriteData=captured data.
  - Then go to XFER if bits remain, else to WB or DONE.
- Throughput with memReady tied high: store 1 cycle/register; load 2 cycles/register; plus 1 DONE cycle.
- DONE: done=1 for one cycle; go to IDLE. busy falls in the same cycle the state returns to IDLE.
- start is ignored while busy.
- memReq is 0 outside XFER. rfWriteEnable is 0 outside WRITE and WB.
- Loads into baseReg are permitted. Without writeback, the loaded value stands.

Optional Feature:
- Macro: REG_BLOCK_WRITEBACK_EN.
- Defined:
  - After the last transfer, enter WB for one cycle: rfWriteEnable=1, rfWriteAddr=baseReg, rfWriteData=baseAddr + 4*count.
  - Then go to DONE.
  - If regList=0, WB is skipped.
  - The WB write overrides any loaded baseReg value, since it is later in time.
- Undefined:
  - WB state is absent; the last transfer goes directly to DONE.
  - baseReg is latched but unused.

Test Plan:
- Store, regList=16'h0005, baseAddr=32'h100, memReady=1, r0=32'hA, r2=32'hB → memory writes 0x100←0xA and 0x104←0xB on consecutive cycles; done pulses in cycle 3; busy high for 3 cycles.
- Load, regList=16'h8001, baseAddr=32'h200, memory returns 0x11 then 0x22 → rfWriteEnable pulses: r0←0x11, then r15←0x22; 5 busy cycles.
- Store, regList=16'h0002, memReady low for 3 cycles → memReq, memAddr and memWData held constant 3 cycles; single write when ready rises.
- regList=0, start=1 → no memReq; done pulses one cycle later.
- Reset mid-load after first memReady → outputs 0 immediately; no rfWriteEnable afterwards; new start works normally.
- With REG_BLOCK_WRITEBACK_EN: load regList=16'h0006, baseAddr=32'hFFFFFFFC, baseReg=4 → addresses 0xFFFFFFFC then 0x0 (wrap); final write r4←32'h4.
